countdown_timer: RTL and testbench

Hours/minutes/seconds countdown timer, the down-counting counterpart of the team's up-counting stopwatch. A preset time is loaded and decremented once per `tick` strobe, with start, pause and resume control. On reaching 00:00:00 the block raises an alarm that stays asserted until acknowledged. Optionally it auto-reloads the preset. It sits beside the stopwatch and shares its `tick` source and display path (`hr`/`min`/`sec` outputs, same widths).

---
 rtl/timer_pkg.sv | 29 ++
 rtl/countdown_timer_hms_dec.sv | 42 ++++
 rtl/countdown_timer.sv | 202 ++++++++++++++++++++
 tb/tb_countdown_timer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and field widths for the hours/minutes/seconds timer family.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

    // Saturate a 6-bit field value to an upper limit.
    function automatic logic [5:0] sat6(input logic [5:0] v, input logic [5:0] lim);
        logic [5:0] r;
        if (v > lim) begin
            r = lim;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_hms_dec.sv
// Combinational h:m:s decrement with borrow, plus zero / one flags for the
// current value. Pairs with the stopwatch's increment cell.
module hms_dec
    import timer_pkg::*;
(
    input  logic [HR_W-1:0]  hr_i,
    input  logic [MIN_W-1:0] min_i,
    input  logic [SEC_W-1:0] sec_i,
    output logic [HR_W-1:0]  hr_o,
    output logic [MIN_W-1:0] min_o,
    output logic [SEC_W-1:0] sec_o,
    output logic             is_one,
    output logic             is_zero
);

    assign is_zero = (hr_i == 5'd0) && (min_i == 6'd0) && (sec_i == 6'd0);
    assign is_one  = (hr_i == 5'd0) && (min_i == 6'd0) && (sec_i == 6'd1);

    // Ripple the borrow from seconds into minutes and hours; hours hold at 0
    // because the caller detects expiry before an underflow could occur.
    always_comb begin
        hr_o  = hr_i;
        min_o = min_i;
        sec_o = sec_i;
        if (sec_i != 6'd0) begin
            sec_o = sec_i - 6'd1;
        end else begin
            sec_o = SEC_MAX;
            if (min_i != 6'd0) begin
                min_o = min_i - 6'd1;
            end else begin
                min_o = MIN_MAX;
                if (hr_i != 5'd0) begin
                    hr_o = hr_i - 5'd1;
                end else begin
                    hr_o = hr_i;
                end
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Hours/minutes/seconds countdown timer with start/pause/resume, latched
// alarm with acknowledge, and optional auto-reload of the stored preset.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int HR_MAX      = 23,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             tick,
    input  logic             load,
    input  logic [HR_W-1:0]  set_hr,
    input  logic [MIN_W-1:0] set_min,
    input  logic [SEC_W-1:0] set_sec,
    input  logic             start,
    input  logic             pause,
    input  logic             ack,
    output logic [HR_W-1:0]  hr,
    output logic [MIN_W-1:0] min,
    output logic [SEC_W-1:0] sec,
    output logic             running,
    output logic             done,
    output logic             alarm
);

    localparam logic [HR_W-1:0] HR_LIM = HR_MAX[HR_W-1:0];

    state_t           state_q, state_d;
    logic [HR_W-1:0]  hr_q, hr_d, pre_hr_q, pre_hr_d;
    logic [MIN_W-1:0] min_q, min_d, pre_min_q, pre_min_d;
    logic [SEC_W-1:0] sec_q, sec_d, pre_sec_q, pre_sec_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             alarm_q, alarm_d;

    logic [HR_W-1:0]  dec_hr_s;
    logic [MIN_W-1:0] dec_min_s;
    logic [SEC_W-1:0] dec_sec_s;
    logic             is_one_s, is_zero_s;
    logic [HR_W-1:0]  clamp_hr_s;
    logic [MIN_W-1:0] clamp_min_s;
    logic [SEC_W-1:0] clamp_sec_s;
    logic             pre_zero_s;

    hms_dec u_dec (
        .hr_i    (hr_q),
        .min_i   (min_q),
        .sec_i   (sec_q),
        .hr_o    (dec_hr_s),
        .min_o   (dec_min_s),
        .sec_o   (dec_sec_s),
        .is_one  (is_one_s),
        .is_zero (is_zero_s)
    );

    assign clamp_sec_s = sat6(set_sec, SEC_MAX);
    assign clamp_min_s = sat6(set_min, MIN_MAX);
    assign pre_zero_s  = (pre_hr_q == 5'd0) && (pre_min_q == 6'd0) && (pre_sec_q == 6'd0);

    // Clamp preset hours to the configured maximum.
    always_comb begin
        if (set_hr > HR_LIM) begin
            clamp_hr_s = HR_LIM;
        end else begin
            clamp_hr_s = set_hr;
        end
    end

    // Next-state, next-count and next-output decode; priority load > ack > start > pause > tick.
    always_comb begin
        state_d   = state_q;
        hr_d      = hr_q;
        min_d     = min_q;
        sec_d     = sec_q;
        pre_hr_d  = pre_hr_q;
        pre_min_d = pre_min_q;
        pre_sec_d = pre_sec_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d   = IDLE;
                    hr_d      = clamp_hr_s;
                    min_d     = clamp_min_s;
                    sec_d     = clamp_sec_s;
                    pre_hr_d  = clamp_hr_s;
                    pre_min_d = clamp_min_s;
                    pre_sec_d = clamp_sec_s;
                end else if (start && !is_zero_s) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // load, ack and start have no effect while counting
                if (pause) begin
                    state_d = PAUSE;
                end else if (tick) begin
                    if (is_one_s) begin
                        done_d = 1'b1;
                        if (AUTO_RELOAD) begin
                            hr_d  = pre_hr_q;
                            min_d = pre_min_q;
                            sec_d = pre_sec_q;
                            if (pre_zero_s) begin
                                state_d = IDLE;
                            end else begin
                                state_d = RUN;
                            end
                        end else begin
                            hr_d    = 5'd0;
                            min_d   = 6'd0;
                            sec_d   = 6'd0;
                            state_d = ALARM;
                        end
                    end else begin
                        hr_d  = dec_hr_s;
                        min_d = dec_min_s;
                        sec_d = dec_sec_s;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (load) begin
                    state_d   = IDLE;
                    hr_d      = clamp_hr_s;
                    min_d     = clamp_min_s;
                    sec_d     = clamp_sec_s;
                    pre_hr_d  = clamp_hr_s;
                    pre_min_d = clamp_min_s;
                    pre_sec_d = clamp_sec_s;
                end else if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = PAUSE;
                end
            end
            ALARM: begin
                if (load) begin
                    state_d   = IDLE;
                    hr_d      = clamp_hr_s;
                    min_d     = clamp_min_s;
                    sec_d     = clamp_sec_s;
                    pre_hr_d  = clamp_hr_s;
                    pre_min_d = clamp_min_s;
                    pre_sec_d = clamp_sec_s;
                end else if (ack) begin
                    state_d = IDLE;
                end else begin
                    state_d = ALARM;
                end
            end
            default: begin
                state_d = IDLE;
                hr_d    = 5'd0;
                min_d   = 6'd0;
                sec_d   = 6'd0;
            end
        endcase
        running_d = (state_d == RUN);
        alarm_d   = (state_d == ALARM);
    end

    // State, count, preset and registered status outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            hr_q      <= 5'd0;
            min_q     <= 6'd0;
            sec_q     <= 6'd0;
            pre_hr_q  <= 5'd0;
            pre_min_q <= 6'd0;
            pre_sec_q <= 6'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hr_q      <= hr_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            pre_hr_q  <= pre_hr_d;
            pre_min_q <= pre_min_d;
            pre_sec_q <= pre_sec_d;
            running_q <= running_d;
            done_q    <= done_d;
            alarm_q   <= alarm_d;
        end
    end

    assign hr      = hr_q;
    assign min     = min_q;
    assign sec     = sec_q;
    assign running = running_q;
    assign done    = done_q;
    assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one instance without and one with
// auto-reload, driven by the same stimulus.
module tb_countdown_timer;

    logic       clk;
    logic       clr_n;
    logic       tick, load, start, pause, ack;
    logic [4:0] set_hr;
    logic [5:0] set_min, set_sec;

    logic [4:0] hr0, hr1;
    logic [5:0] min0, sec0, min1, sec1;
    logic       running0, done0, alarm0;
    logic       running1, done1, alarm1;

    int n_checks;
    int n_pass;

    countdown_timer #(.HR_MAX(23), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .clr_n(clr_n), .tick(tick), .load(load),
        .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec),
        .start(start), .pause(pause), .ack(ack),
        .hr(hr0), .min(min0), .sec(sec0),
        .running(running0), .done(done0), .alarm(alarm0)
    );

    countdown_timer #(.HR_MAX(23), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .clr_n(clr_n), .tick(tick), .load(load),
        .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec),
        .start(start), .pause(pause), .ack(ack),
        .hr(hr1), .min(min1), .sec(sec1),
        .running(running1), .done(done1), .alarm(alarm1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] hms(input int h, input int m, input int s);
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
        hh = h[4:0];
        mm = m[5:0];
        ss = s[5:0];
        return {15'd0, hh, mm, ss};
    endfunction

    function automatic logic [31:0] cnt0();
        return {15'd0, hr0, min0, sec0};
    endfunction

    function automatic logic [31:0] cnt1();
        return {15'd0, hr1, min1, sec1};
    endfunction

    function automatic logic [31:0] b(input logic v);
        return {31'd0, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ld, input logic st, input logic ps,
                        input logic ak, input logic tk);
        load  = ld;
        start = st;
        pause = ps;
        ack   = ak;
        tick  = tk;
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        ack   = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic preset(input int h, input int m, input int s);
        set_hr  = h[4:0];
        set_min = m[5:0];
        set_sec = s[5:0];
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clr_n    = 1'b1;
        tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; ack = 1'b0;
        set_hr = 5'd0; set_min = 6'd0; set_sec = 6'd0;
        #1 clr_n = 1'b0;
        #2;
        check("rst_cnt",     cnt0(), hms(0, 0, 0));
        check("rst_running", b(running0), 32'd0);
        check("rst_done",    b(done0), 32'd0);
        check("rst_alarm",   b(alarm0), 32'd0);
        @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;

        // 1: load 00:00:03 and expire
        preset(0, 0, 3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_load", cnt0(), hms(0, 0, 3));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_run", b(running0), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_tick1", cnt0(), hms(0, 0, 2));
        check("t1_nodone1", b(done0), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_tick2", cnt0(), hms(0, 0, 1));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_tick3", cnt0(), hms(0, 0, 0));
        check("t1_done", b(done0), 32'd1);
        check("t1_alarm", b(alarm0), 32'd1);
        check("t1_stopped", b(running0), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_done_off", b(done0), 32'd0);
        check("t1_alarm_hold", b(alarm0), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_ack_alarm", b(alarm0), 32'd0);
        check("t1_ack_cnt", cnt0(), hms(0, 0, 0));

        // 2: borrow chain
        preset(1, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_borrow", cnt0(), hms(0, 59, 59));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_next", cnt0(), hms(0, 59, 58));
        preset(5, 5, 5);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_load_in_run", cnt0(), hms(0, 59, 58));
        check("t4_load_in_run_st", b(running0), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_pause", b(running0), 32'd0);

        // 3: clamp and start at zero
        preset(31, 63, 60);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_clamp", cnt0(), hms(23, 59, 59));
        preset(0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_zero_start", b(running0), 32'd0);
        check("t3_zero_cnt", cnt0(), hms(0, 0, 0));

        // 4: pause / start precedence over tick
        preset(0, 0, 10);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_run", b(running0), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t4_pause_st", b(running0), 32'd0);
        check("t4_pause_cnt", cnt0(), hms(0, 0, 10));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_paused_ticks", cnt0(), hms(0, 0, 10));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t4_resume_st", b(running0), 32'd1);
        check("t4_resume_cnt", cnt0(), hms(0, 0, 10));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_after_resume", cnt0(), hms(0, 0, 9));

        // 5: auto-reload instance
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        preset(0, 0, 2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_run", b(running1), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_c1", cnt1(), hms(0, 0, 1));
        check("t5_d1", b(done1), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_c2", cnt1(), hms(0, 0, 2));
        check("t5_d2", b(done1), 32'd1);
        check("t5_r2", b(running1), 32'd1);
        check("t5_a2", b(alarm1), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_c3", cnt1(), hms(0, 0, 1));
        check("t5_d3", b(done1), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_c4", cnt1(), hms(0, 0, 2));
        check("t5_d4", b(done1), 32'd1);
        check("t5_r4", b(running1), 32'd1);
        check("t5_a4", b(alarm1), 32'd0);

        // 6: asynchronous reset while the non-reload instance is in ALARM
        check("t6_pre_alarm", b(alarm0), 32'd1);
        #2;
        clr_n = 1'b0;
        #1;
        check("t6_alarm", b(alarm0), 32'd0);
        check("t6_cnt0", cnt0(), hms(0, 0, 0));
        check("t6_cnt1", cnt1(), hms(0, 0, 0));
        check("t6_run1", b(running1), 32'd0);
        check("t6_done1", b(done1), 32'd0);
        #1;
        clr_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t6_tick_idle", cnt0(), hms(0, 0, 0));
        check("t6_idle_st", b(running0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
